systolic_2x2_controller: RTL
============================

// Module: systolic_2x2_controller
// PURPOSE
//  Sequencer for the 2x2 systolic matrix-multiplier array. Latches a 2x2 A and B operand pair on start.
//  Streams them diagonally skewed into the array's row/column inputs and waits for the array's done pulse.
//  Captures the four results into a registered C matrix and flags it valid. Sits between host/bus logic and the array.
// PARAMETERS
//  DATA_W       2   operand element width (unsigned)
//  RES_W        5   result element width (unsigned); DATA_W*2+1
//  TIMEOUT_CYC  16  WAIT-state watchdog limit in cycles (used only with SA_TIMEOUT_EN)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst          in   1         synchronous, active-high reset
//  start        in   1         request; sampled only in IDLE
//  a_mat        in   4*DATA_W  {a11,a10,a01,a00}, A[row][col]
//  b_mat        in   4*DATA_W  {b11,b10,b01,b00}, B[row][col]
//  busy         out  1         high in FEED and WAIT
//  sa_load_in   out  1         to array load_in
//  sa_row0/1    out  DATA_W    to array row inputs 0/1
//  sa_col0/1    out  DATA_W    to array column inputs 0/1
//  sa_res00..11 in   RES_W     array results C[r][c]
//  sa_done      in   1         array completion pulse
//  c_mat        out  4*RES_W   {c11,c10,c01,c00}, registered
//  c_valid      out  1         one-cycle pulse: c_mat updated
//  timeout_err  out  1         one-cycle pulse: watchdog fired (0 when macro absent)
// BEHAVIOUR
//  Reset: state=IDLE; busy, sa_load_in, sa_row*, sa_col*, c_valid, timeout_err = 0; c_mat = 0; FEED counter = 0.
//  FSM: IDLE -> FEED (3 cycles) -> WAIT -> IDLE.
//  IDLE: start=1 at edge k latches a_mat/b_mat into internal regs; FEED active k+1..k+3.
//   start while busy is ignored (no queue, no error).
//  FEED: all sa_* outputs registered; sa_load_in=1 in all 3 FEED cycles, 0 otherwise.
//   Skew schedule:
//     F0: row0=a00 row1=0   col0=b00 col1=0
//     F1: row0=a01 row1=a10 col0=b10 col1=b01
//     F2: row0=0   row1=a11 col0=0   col1=b11
//   Outside FEED all sa_row*/sa_col* = 0.
//  WAIT: entered at k+4; busy=1.
//   sa_done=1 at edge m: capture sa_res00..11 into c_mat, c_valid=1 in cycle m+1, state=IDLE in m+1.
//  Min latency: start edge -> c_valid = 4 cycles + array response time.
//  Back-to-back: busy=0 in the c_valid cycle; start in that cycle is accepted.
//  sa_done outside WAIT (IDLE or FEED) is ignored; c_mat is held.
//  No arithmetic in the block: results pass through at RES_W; c_mat changes only on capture or reset.
//  Operand regs change only on an accepted start; a_mat/b_mat may change freely afterwards.
//  rst mid-FEED/WAIT: abort immediately to reset values; next-cycle sa_done is ignored (IDLE).
// CONFIGURATION
//  SA_TIMEOUT_EN defined:
//   - A counter clears on WAIT entry and counts each WAIT cycle without sa_done.
//   - Reaching TIMEOUT_CYC: timeout_err=1 for one cycle, state=IDLE, c_valid stays 0, c_mat unchanged.
//   - sa_done in the same cycle the limit is reached wins: normal capture, no error.
//  SA_TIMEOUT_EN undefined: no counter; WAIT holds until sa_done or rst; timeout_err tied 0.
// TESTING
//  1. rst 2 cycles -> all outputs 0, busy=0; start held high during rst -> no FEED.
//  2. A=[[1,2],[3,1]], B=[[2,1],[1,3]], start 1 cycle, model returns sa_done 3 cycles after F2
//     -> skew exactly per table, sa_load_in high 3 cycles, c_valid once, C=[[4,7],[7,6]].
//  3. A=B=all 3 -> c_mat every element 18 (no truncation at RES_W=5).
//  4. start pulsed in F1 and in WAIT -> ignored; start in c_valid cycle -> second FEED begins next cycle.
//  5. rst asserted in WAIT, sa_done pulsed next cycle -> stays IDLE, c_valid=0, c_mat=0.
//  6. SA_TIMEOUT_EN, no sa_done -> timeout_err pulse after 16 WAIT cycles, IDLE, c_mat unchanged;
//     sa_done on cycle 16 -> capture instead; macro undefined -> WAIT holds 100 cycles, timeout_err=0.

Source files
------------

// File: rtl/systolic_2x2_controller.sv
// Sequencer for the 2x2 systolic array: latches A/B, feeds them diagonally skewed, captures C on sa_done.
// Optional WAIT-state watchdog is compiled in with `define SA_TIMEOUT_EN.
module systolic_2x2_controller #(
    parameter int DATA_W      = 2,
    parameter int RES_W       = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DATA_W-1:0] a_mat,
    input  logic [4*DATA_W-1:0] b_mat,
    output logic                busy,
    output logic                sa_load_in,
    output logic [DATA_W-1:0]   sa_row0,
    output logic [DATA_W-1:0]   sa_row1,
    output logic [DATA_W-1:0]   sa_col0,
    output logic [DATA_W-1:0]   sa_col1,
    input  logic [RES_W-1:0]    sa_res00,
    input  logic [RES_W-1:0]    sa_res01,
    input  logic [RES_W-1:0]    sa_res10,
    input  logic [RES_W-1:0]    sa_res11,
    input  logic                sa_done,
    output logic [4*RES_W-1:0]  c_mat,
    output logic                c_valid,
    output logic                timeout_err
);
    // state | meaning
    // IDLE  | waiting for start; operands latched on accept
    // FEED  | three skewed load cycles into the array
    // WAIT  | waiting for sa_done (or watchdog expiry)
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FEED = 2'd1, S_WAIT = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [1:0]          feed_cnt_q, feed_cnt_d;
    logic [4*DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic                load_q, load_d;
    logic [DATA_W-1:0]   row0_q, row0_d, row1_q, row1_d;
    logic [DATA_W-1:0]   col0_q, col0_d, col1_q, col1_d;
    logic [4*RES_W-1:0]  c_q, c_d;
    logic                c_valid_q, c_valid_d;
`ifdef SA_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                tmo_q, tmo_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            feed_cnt_q <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            load_q     <= 1'b0;
            row0_q     <= '0;
            row1_q     <= '0;
            col0_q     <= '0;
            col1_q     <= '0;
            c_q        <= '0;
            c_valid_q  <= 1'b0;
`ifdef SA_TIMEOUT_EN
            wd_q       <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            load_q     <= load_d;
            row0_q     <= row0_d;
            row1_q     <= row1_d;
            col0_q     <= col0_d;
            col1_q     <= col1_d;
            c_q        <= c_d;
            c_valid_q  <= c_valid_d;
`ifdef SA_TIMEOUT_EN
            wd_q       <= wd_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    // feed_cnt counts remaining FEED cycles: 2 in F0, 1 in F1, 0 in F2.
    always_comb begin
        state_d    = state_q;
        feed_cnt_d = feed_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        load_d     = 1'b0;
        row0_d     = '0;
        row1_d     = '0;
        col0_d     = '0;
        col1_d     = '0;
        c_d        = c_q;
        c_valid_d  = 1'b0;
`ifdef SA_TIMEOUT_EN
        wd_d       = wd_q;
        tmo_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FEED;
                    feed_cnt_d = 2'd2;
                    a_d        = a_mat;
                    b_d        = b_mat;
                    load_d     = 1'b1;
                    row0_d     = a_mat[0*DATA_W +: DATA_W];
                    col0_d     = b_mat[0*DATA_W +: DATA_W];
                end
            end
            S_FEED: begin
                if (feed_cnt_q == 2'd0) begin
                    state_d = S_WAIT;
`ifdef SA_TIMEOUT_EN
                    wd_d    = WD_W'(TIMEOUT_CYC - 1);
`endif
                end else begin
                    feed_cnt_d = feed_cnt_q - 2'd1;
                    load_d     = 1'b1;
                    if (feed_cnt_q == 2'd2) begin
                        row0_d = a_q[1*DATA_W +: DATA_W];
                        row1_d = a_q[2*DATA_W +: DATA_W];
                        col0_d = b_q[2*DATA_W +: DATA_W];
                        col1_d = b_q[1*DATA_W +: DATA_W];
                    end else begin
                        row1_d = a_q[3*DATA_W +: DATA_W];
                        col1_d = b_q[3*DATA_W +: DATA_W];
                    end
                end
            end
            S_WAIT: begin
                if (sa_done) begin
                    c_d       = {sa_res11, sa_res10, sa_res01, sa_res00};
                    c_valid_d = 1'b1;
                    state_d   = S_IDLE;
                end
`ifdef SA_TIMEOUT_EN
                else if (wd_q == '0) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign sa_load_in = load_q;
    assign sa_row0    = row0_q;
    assign sa_row1    = row1_q;
    assign sa_col0    = col0_q;
    assign sa_col1    = col1_q;
    assign c_mat      = c_q;
    assign c_valid    = c_valid_q;
`ifdef SA_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif
endmodule
